fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and issues word fetches to instruction memory over a request/grant plus response-valid handshake.
- Buffers one fetched instruction and presents it, with its PC, PC+4 and pre-sliced decode fields (OPCode, funct3, funct75), to decode over a valid/ready handshake.
- Accepts redirects from branch/jump resolution (PCNextIn path) and discards any stale in-flight fetch.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imemReq  out  1  fetch request valid.
- imemAddr  out  XLEN  word-aligned fetch address; equals pc.
- imemGnt  in  1  memory accepts request this cycle when imemReq=1.
- imemRValid  in  1  response data valid.
- imemRData  in  32  fetched instruction word.
- redirect  in  1  take redirectPC; from resolved branch/jump.
- redirectPC  in  XLEN  redirect target.
- instrValid  out  1  instruction buffer holds a valid instruction.
- instrReady  in  1  decode consumes the buffer this cycle.
- instr  out  32  buffered instruction.
- instrPC  out  XLEN  PC of the buffered instruction.
- instrPCPlus4  out  XLEN  instrPC+4, modulo 2^XLEN.
- OPCode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct75  out  1  instr[30].

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=FETCH, drop=0.
  - instrValid=0; instr, instrPC and instrPCPlus4 all 0.
  - imemReq=0 while reset is high.
- Invariants:
  - At most one outstanding request.
  - Buffer depth is 1.
  - pc[1:0] is always 0: redirectPC[1:0] is ignored (forced to 0).
- canIssue = !instrValid || instrReady.
- State FETCH:
  - imemReq = canIssue && !redirect.
  - imemReq && imemGnt: pc <= pc+4 (wraps), latch reqPC <= pc, go to WAIT, drop=0.
  - redirect: pc <= redirectPC, no request this cycle, stay in FETCH.
  - imemRValid is ignored in FETCH (stale responses after reset or drop).
- State WAIT:
  - imemReq=0.
  - imemRValid && !drop && !redirect: instr <= imemRData, instrPC <= reqPC, instrPCPlus4 <= reqPC+4, instrValid <= 1, go to FETCH.
  - imemRValid && (drop || redirect): discard data, go to FETCH, drop <= 0.
  - redirect without imemRValid: pc <= redirectPC, drop <= 1, stay in WAIT.
- Buffer:
  - instrValid clears when instrReady && instrValid and no new fill that cycle.
  - instrValid clears on redirect; redirect has priority over fill and hold.
  - The buffer is guaranteed free when a response arrives, because issue requires canIssue. An instrReady=0 stall after issue cannot occur with a full buffer.
- Simultaneous events:
  - redirect has priority over imemGnt in FETCH; no request is driven, so a grant is impossible.
  - redirect with instrReady: buffer cleared, consume is irrelevant.
- Throughput: 1 instruction per 2 cycles minimum with 1-cycle memory latency (grant cycle, response cycle).
- Outputs are registered except imemReq and imemAddr, which come from state/pc plus canIssue and redirect. Decode fields are wire slices of instr.
- Reset mid-WAIT: outstanding response is ignored because the state is FETCH after reset. The memory side must tolerate an orphan response.

Decomposition:
- Shared core package:
  - XLEN default.
  - RESET_PC default.
  - Opcode field position constants (OPC_LSB/MSB, F3_LSB/MSB, F75_BIT).
  - Fetch state enum {FETCH, WAIT}.
- One natural sub-module: fetch_buffer. One-entry instruction/PC register with valid/ready and flush; reusable for a future 2-entry skid buffer.
- PC/FSM logic stays in fetch_unit.

Test Plan:
- Reset then grant every cycle, 1-cycle response: imemAddr 0x0, 0x4, 0x8. instr/instrPC pairs (0x00000013,0x0), (…,0x4) appear with instrValid, one per 2 cycles; instrPCPlus4 = instrPC+4.
- Decode stall: instrReady=0 for 5 cycles with buffer full → imemReq stays 0, instr/instrPC held. instrReady=1 → imemReq=1 the same cycle.
- Redirect in WAIT to 0x100, then response 0xDEADBEEF → response discarded, instrValid stays 0. Next imemAddr=0x100; next delivered instrPC=0x100.
- Redirect coincident with imemRValid in WAIT, target 0x203 → data dropped, instrValid=0. Next imemAddr=0x200 (low bits forced 0).
- PC wrap: RESET_PC=0xFFFF_FFFC → first fetch 0xFFFF_FFFC, instrPCPlus4=0x0, next imemAddr=0x0.
- Async reset asserted mid-WAIT (between clock edges) → instrValid=0 and imemReq=0 immediately. A late imemRValid after release is ignored; first fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC,
// instruction field positions and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F75_BIT = 30;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction/PC holding register with valid/ready and flush.
// Flush wins over fill, and fill wins over consume.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_fill,
  input  logic [31:0]     i_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_ready,
  output logic            o_valid,
  output logic            o_can_accept,
  output logic [31:0]     o_data,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic            r_valid;
  logic [31:0]     r_data;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= 32'h0000_0000;
      r_pc       <= {XLEN{1'b0}};
      r_pc_plus4 <= {XLEN{1'b0}};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid    <= 1'b1;
      r_data     <= i_data;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc + PC_STEP;
    end else if (i_ready && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  // The slot is free for a new fetch when empty or being drained this cycle.
  assign o_can_accept = !r_valid || i_ready;
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_pc         = r_pc;
  assign o_pc_plus4   = r_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding word fetches
// and hands one buffered instruction with pre-sliced decode fields to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemGnt,
  input  logic            imemRValid,
  input  logic [31:0]     imemRData,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPC,
  output logic            instrValid,
  input  logic            instrReady,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instrPC,
  output logic [XLEN-1:0] instrPCPlus4,
  output logic [6:0]      OPCode,
  output logic [2:0]      funct3,
  output logic            funct75
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_drop;
  logic            w_can_issue;
  logic            w_imem_req;
  logic            w_issue;
  logic            w_fill;
  logic            w_in_wait;
  logic [XLEN-1:0] w_redirect_pc;
  logic [1:0]      w_unused_lo;

  // Redirect targets are forced word aligned; the low bits are dropped.
  assign w_redirect_pc = {redirectPC[XLEN-1:2], 2'b00};
  assign w_unused_lo   = redirectPC[1:0];
  assign w_issue       = w_imem_req && imemGnt;
  assign w_in_wait     = (r_state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (w_issue) begin
          w_next_state = WAIT;
        end else begin
          w_next_state = FETCH;
        end
      end
      WAIT: begin
        if (imemRValid) begin
          w_next_state = FETCH;
        end else begin
          w_next_state = WAIT;
        end
      end
      default: w_next_state = FETCH;
    endcase
  end

  // Request and fill strobes; redirect suppresses both in the same cycle.
  always_comb begin
    w_imem_req = 1'b0;
    w_fill     = 1'b0;
    case (r_state)
      FETCH: begin
        if (!reset && w_can_issue && !redirect) begin
          w_imem_req = 1'b1;
        end else begin
          w_imem_req = 1'b0;
        end
        w_fill = 1'b0;
      end
      WAIT: begin
        w_imem_req = 1'b0;
        if (imemRValid && !r_drop && !redirect) begin
          w_fill = 1'b1;
        end else begin
          w_fill = 1'b0;
        end
      end
      default: begin
        w_imem_req = 1'b0;
        w_fill     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_req_pc <= {XLEN{1'b0}};
      r_drop   <= 1'b0;
    end else begin
      if (redirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + PC_STEP;
      end
      if (w_issue) begin
        r_req_pc <= r_pc;
      end
      // A redirect while waiting poisons the in-flight response.
      if (w_issue) begin
        r_drop <= 1'b0;
      end else if (w_in_wait && imemRValid) begin
        r_drop <= 1'b0;
      end else if (w_in_wait && redirect) begin
        r_drop <= 1'b1;
      end
    end
  end

  fetch_buffer #(
    .XLEN(XLEN)
  ) u_fetch_buffer (
    .clk         (clk),
    .rst         (reset),
    .i_flush     (redirect),
    .i_fill      (w_fill),
    .i_data      (imemRData),
    .i_pc        (r_req_pc),
    .i_ready     (instrReady),
    .o_valid     (instrValid),
    .o_can_accept(w_can_issue),
    .o_data      (instr),
    .o_pc        (instrPC),
    .o_pc_plus4  (instrPCPlus4)
  );

  assign imemReq  = w_imem_req;
  assign imemAddr = r_pc;
  assign OPCode   = instr[OPC_MSB:OPC_LSB];
  assign funct3   = instr[F3_MSB:F3_LSB];
  assign funct75  = instr[F75_BIT];

endmodule
